// File: rtl/mesh_router_sync.sv
// Clocked mesh tile router: per-input FIFOs, XY dimension-order routing, per-output
// round-robin arbitration and registered req/data outputs. Single-flit packets.
module mesh_router_sync #(
    parameter int unsigned N       = 32,
    parameter int unsigned XW      = 2,
    parameter int unsigned YW      = 2,
    parameter int unsigned SRCX    = 0,
    parameter int unsigned SRCY    = 0,
    parameter int unsigned DEPTH   = 4,
    parameter logic [4:0]  PORT_EN = 5'b11111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       in_req,
    input  logic [5*N-1:0]   in_data,
    output logic [4:0]       in_ack,
    output logic [4:0]       out_req,
    output logic [5*N-1:0]   out_data,
    input  logic [4:0]       out_ack,
    output logic [4:0]       err_drop
);
    localparam int unsigned NP = 5;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    logic [N-1:0]    mem    [NP][DEPTH];
    logic [AW-1:0]   wr_ptr [NP];
    logic [AW-1:0]   rd_ptr [NP];
    logic [CW-1:0]   count  [NP];
    logic [2:0]      rr     [NP];

    logic [N-1:0]    head   [NP];
    logic [XW-1:0]   dst_x  [NP];
    logic [YW-1:0]   dst_y  [NP];
    logic [2:0]      target [NP];
    logic [2:0]      winner [NP];
    logic [NP-1:0]   full, has_head, routable, drop, push, pop, free, win_any;

    // Head decode, XY route selection and input-side handshake.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            full[p]     = (count[p] == CW'(DEPTH));
            has_head[p] = PORT_EN[p] && (count[p] != '0);
            head[p]     = mem[p][rd_ptr[p]];
            dst_x[p]    = head[p][N-1 -: XW];
            dst_y[p]    = head[p][N-1-XW -: YW];
            if (dst_x[p] > XW'(SRCX))
                target[p] = P_EAST;
            else if (dst_x[p] < XW'(SRCX))
                target[p] = P_WEST;
            else if (dst_y[p] > YW'(SRCY))
                target[p] = P_NORTH;
            else if (dst_y[p] < YW'(SRCY))
                target[p] = P_SOUTH;
            else
                target[p] = P_LOCAL;
            // U-turns are unroutable except LOCAL back to LOCAL.
            routable[p] = PORT_EN[target[p]] && !((target[p] == 3'(p)) && (p != 0));
            drop[p]     = has_head[p] && !routable[p];
            in_ack[p]   = PORT_EN[p] && !rst && !full[p];
            push[p]     = in_req[p] && in_ack[p];
        end
    end

    // Per-output round robin starting at rr[o]; a head requests exactly one output.
    always_comb begin : arb
        logic [2:0] idx;
        idx = 3'd0;
        pop = drop;
        for (int o = 0; o < NP; o++) begin
            free[o]    = PORT_EN[o] && (!out_req[o] || out_ack[o]);
            win_any[o] = 1'b0;
            winner[o]  = 3'd0;
            for (int k = 0; k < NP; k++) begin
                idx = 3'((32'(rr[o]) + 32'(k)) % 32'(NP));
                if (free[o] && !win_any[o] && has_head[idx] && routable[idx]
                    && (target[idx] == 3'(o))) begin
                    win_any[o] = 1'b1;
                    winner[o]  = idx;
                end
            end
            if (win_any[o])
                pop[winner[o]] = 1'b1;
        end
    end

    // FIFO pointers, output registers and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
                rr[p]     <= '0;
            end
            out_req  <= '0;
            out_data <= '0;
            err_drop <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p])
                    wr_ptr[p] <= AW'(wr_ptr[p] + AW'(1));
                if (pop[p])
                    rd_ptr[p] <= AW'(rd_ptr[p] + AW'(1));
                count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
            end
            err_drop <= drop;
            for (int o = 0; o < NP; o++) begin
                if (free[o]) begin
                    out_req[o] <= win_any[o];
                    if (win_any[o]) begin
                        out_data[o*N +: N] <= head[winner[o]];
                        rr[o] <= (winner[o] == 3'd4) ? 3'd0 : winner[o] + 3'd1;
                    end
                end
            end
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p])
                mem[p][wr_ptr[p]] <= in_data[p*N +: N];
        end
    end

endmodule
